fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that sequences the byte-wide, byte-addressed instruction memory. Reads four consecutive bytes per instruction, assembles them big-endian into a 32-bit word and hands it to the decode stage with a valid/ready handshake. Also handles branch/jump redirects and stops fetching when the program ends. Sits between the PC/branch logic and the instruction memory; it is the only master of the memory read port.

## Interface
- `ADDR_W`, default 32: width of the PC and the memory address.
- `RESET_PC`, default 0: PC loaded on reset; must be a multiple of 4.
- `MEM_BYTES`, default 256: instruction memory size in bytes; a multiple of 4.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `mem_rd`  out  1: byte read strobe to instruction memory.
- `mem_addr`  out  ADDR_W: byte address of the read.
- `mem_rdata`  in  8: read data. Valid in the cycle after `mem_rd` (synchronous read, 1-cycle latency).
- `instr`  out  32: assembled instruction; stable while `instr_valid`.
- `instr_pc`  out  ADDR_W: address of `instr`.
- `instr_valid`  out  1: `instr`/`instr_pc` valid.
- `instr_ready`  in  1: consumer accepts when `instr_valid && instr_ready` at a rising edge.
- `redirect`  in  1: branch/jump taken; single-cycle pulse.
- `redirect_pc`  in  ADDR_W: new PC. Bits [1:0] are ignored and treated as zero.
- `halted`  out  1: program finished; sticky until reset.

## Operation
- Reset values:
  - `pc` = `RESET_PC`, state FETCH, `cnt` = 0.
  - `mem_rd` = 0, `mem_addr` = `RESET_PC`.
  - `instr` = 0, `instr_pc` = `RESET_PC`, `instr_valid` = 0, `halted` = 0.
- FETCH:
  - Issues `mem_rd` = 1 with `mem_addr` = `pc` + `cnt` for `cnt` = 0..3 on consecutive cycles.
  - Each cycle after an issue, shifts `mem_rdata` into the assembly register: `word` = {`word`[23:0], `mem_rdata`}.
  - After issuing `cnt` = 3, goes to DRAIN.
- DRAIN (`mem_rd` = 0): captures the last byte, then evaluates the assembled word.
  - Word == 32'h0 goes to HALT. No `instr_valid` for the zero word.
  - Any other word goes to HOLD, with `instr` = `word`, `instr_pc` = `pc`, `instr_valid` = 1.
- HOLD: holds `instr_valid` until accepted. On acceptance:
  - `pc` += 4, `instr_valid` = 0.
  - If the new `pc` > `MEM_BYTES` − 4, goes to HALT; otherwise goes to FETCH with `cnt` = 0.
- HALT:
  - `halted` = 1, `mem_rd` = 0, `instr_valid` = 0.
  - Ignores `redirect`; exits only on `rst`.
- Redirect (any state except HALT) has priority over all other transitions in that cycle:
  - In-flight bytes are discarded and `instr_valid` drops the next cycle; a pending instruction in HOLD is dropped even if `instr_ready` is high in that cycle.
  - `pc` = {`redirect_pc`[ADDR_W−1:2], 2'b00}, `cnt` = 0, state FETCH.
  - If the target is > `MEM_BYTES` − 4, goes to HALT instead.
- A `RESET_PC` out of range halts on the first cycle after reset without issuing any read.
- PC arithmetic is modulo 2^ADDR_W. The range check is done on the full-width value, before any wrap.

## Timing
- First `mem_rd` is in the first cycle after `rst` deasserts.
- Latency: if byte 0 issues in cycle c, `instr_valid` is high from cycle c+5.
- Throughput: 6 cycles per instruction when `instr_ready` is tied high.
- The next fetch issues in the cycle after acceptance.
- Redirect seen at edge e: `mem_rd` for the new pc is high in the cycle following e.
- `rst` asserted mid-fetch forces all reset values immediately (asynchronously).
- `mem_addr` is don't-care while `mem_rd` = 0 but holds its last value (no toggling).

## Structure
- Shared package `fetch_pkg` holds:
  - state enum {FETCH, DRAIN, HOLD, HALT}
  - `BYTES_PER_WORD` = 4
  - `HALT_WORD` = 32'h0000_0000
- One natural sub-module, `fetch_word_assembler`: 32-bit shift register with `shift_en` and `clear`.
- FSM, PC register and byte counter stay in the top.

## Test plan
- Memory bytes 0..7 = 20 08 00 05 01 09 50 20, then zeros; `instr_ready` tied 1:
  - `instr` = 32'h20080005 @pc 0, then 32'h01095020 @pc 4.
  - `halted` = 1 after the word at pc 8 is read.
  - Exactly 12 `mem_rd` cycles issued before HALT.
- Same image, `instr_ready` low for 10 cycles after the first `instr_valid`: `instr` and `instr_pc` hold unchanged, and no `mem_rd` occurs during the stall.
- Redirect with `redirect_pc` = 32'h0000000E during byte 2 of the pc-0 fetch:
  - The partial word is never presented.
  - The next `mem_rd` address is 12; the next `instr_pc` is 12.
- `MEM_BYTES` = 8 with a non-zero image: after the pc-4 instruction is accepted, `halted` = 1 and `mem_addr` never reaches 8.
- Assert `rst` during DRAIN with `instr_valid` = 0:
  - Outputs return to reset values immediately.
  - After release, the fetch restarts at `RESET_PC` with byte 0.
- Redirect pulses in HALT: no `mem_rd`, `halted` stays 1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic [31:0] HALT_WORD      = 32'h0000_0000;

endpackage

// File: rtl/fetch_word_assembler.sv
// Big-endian 32-bit assembly register: each shifted byte becomes the new LSB.
// word_next_o is the value the register takes at the next edge (absent a
// clear), so the owner can inspect a completed word in the same cycle the
// final byte arrives.
module fetch_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        shift_en_i,
  input  logic        clear_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_next_o
);

  logic [31:0] word_q;

  // Next word: shift the incoming byte in when enabled, otherwise hold.
  always_comb begin
    word_next_o = shift_en_i ? {word_q[23:0], byte_i} : word_q;
  end

  // Assembly register; clear wins over shift so a discarded fetch leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else if (clear_i) begin
      word_q <= '0;
    end else begin
      word_q <= word_next_o;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: reads four bytes per instruction from a
// byte-wide synchronous memory, presents the assembled word to decode with a
// valid/ready handshake, follows redirects and halts on a zero word or when
// the PC runs past the end of memory.
//
// Byte 0 of a new PC is issued on the same edge that decides to fetch it
// (acceptance, redirect), so the internal counter already points at byte 1
// afterwards. This gives the next read in the cycle right after the event.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
  // Highest legal word address; compared on ADDR_W+1 bits so a wrapped PC
  // still reads as out of range.
  localparam logic [ADDR_W:0]   PC_LIMIT = (ADDR_W+1)'(MEM_BYTES - BYTES_PER_WORD);
  localparam logic [1:0]        LAST_CNT = 2'(BYTES_PER_WORD - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [1:0]          cnt_q;
  logic                data_vld_q;   // mem_rdata carries a byte we asked for
  logic                mem_rd_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         instr_q;
  logic [ADDR_W-1:0]   instr_pc_q;
  logic                instr_valid_q;
  logic                halted_q;

  logic                redirect_live;
  logic [ADDR_W-1:0]   redirect_tgt;
  logic [ADDR_W-1:0]   byte_addr;
  logic [ADDR_W:0]     pc_plus4;
  logic [31:0]         word_next;
  logic                shift_en;
  logic                asm_clear;

  // Address arithmetic and assembler control.
  always_comb begin
    redirect_live = redirect && (state_q != HALT);
    redirect_tgt  = redirect_pc & ~ADDR_W'(3);
    byte_addr     = pc_q + ADDR_W'(cnt_q);
    pc_plus4      = {1'b0, pc_q} + (ADDR_W+1)'(BYTES_PER_WORD);
    shift_en      = data_vld_q && !redirect_live;
    asm_clear     = redirect_live;
  end

  fetch_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (shift_en),
    .clear_i    (asm_clear),
    .byte_i     (mem_rdata),
    .word_next_o(word_next)
  );

  // Fetch FSM with PC, byte counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= PC_RESET;
      cnt_q         <= '0;
      data_vld_q    <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= PC_RESET;
      instr_q       <= '0;
      instr_pc_q    <= PC_RESET;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      data_vld_q <= mem_rd_q;
      if (state_q == HALT) begin
        mem_rd_q      <= 1'b0;
        instr_valid_q <= 1'b0;
        halted_q      <= 1'b1;
        data_vld_q    <= 1'b0;
      end else if (redirect_live) begin
        // Drop everything in flight, including a word waiting in HOLD.
        data_vld_q    <= 1'b0;
        instr_valid_q <= 1'b0;
        pc_q          <= redirect_tgt;
        if ({1'b0, redirect_tgt} > PC_LIMIT) begin
          state_q  <= HALT;
          halted_q <= 1'b1;
          mem_rd_q <= 1'b0;
          cnt_q    <= '0;
        end else begin
          state_q    <= FETCH;
          mem_rd_q   <= 1'b1;
          mem_addr_q <= redirect_tgt;
          cnt_q      <= 2'd1;
        end
      end else begin
        case (state_q)
          FETCH: begin
            if (cnt_q == 2'd0 && {1'b0, pc_q} > PC_LIMIT) begin
              // Only reachable with an out-of-range reset PC.
              state_q  <= HALT;
              halted_q <= 1'b1;
              mem_rd_q <= 1'b0;
            end else begin
              mem_rd_q   <= 1'b1;
              mem_addr_q <= byte_addr;
              cnt_q      <= cnt_q + 2'd1;
              if (cnt_q == LAST_CNT) begin
                state_q <= DRAIN;
              end
            end
          end
          DRAIN: begin
            mem_rd_q <= 1'b0;
            // The last read is still being issued while mem_rd_q is high;
            // once it drops, this edge captures the final byte.
            if (!mem_rd_q) begin
              if (word_next == HALT_WORD) begin
                state_q  <= HALT;
                halted_q <= 1'b1;
              end else begin
                state_q       <= HOLD;
                instr_q       <= word_next;
                instr_pc_q    <= pc_q;
                instr_valid_q <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (instr_ready) begin
              instr_valid_q <= 1'b0;
              pc_q          <= pc_plus4[ADDR_W-1:0];
              if (pc_plus4 > PC_LIMIT) begin
                state_q  <= HALT;
                halted_q <= 1'b1;
              end else begin
                state_q    <= FETCH;
                mem_rd_q   <= 1'b1;
                mem_addr_q <= pc_plus4[ADDR_W-1:0];
                cnt_q      <= 2'd1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected {instr, pc} pairs are queued
// when a scenario starts and popped on each accepted handshake.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 256-byte memory, driven by the scenario sequence.
  logic        rst = 1'b1;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halted;

  // DUT B: 8-byte memory, free-running with ready tied high.
  logic        rst_b = 1'b1;
  logic        mem_rd_b;
  logic [31:0] mem_addr_b;
  logic [7:0]  mem_rdata_b;
  logic [31:0] instr_b;
  logic [31:0] instr_pc_b;
  logic        instr_valid_b;
  logic        halted_b;

  fetch_sequencer #(.ADDR_W(32), .RESET_PC(0), .MEM_BYTES(256)) dut_a (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );

  fetch_sequencer #(.ADDR_W(32), .RESET_PC(0), .MEM_BYTES(8)) dut_b (
    .clk(clk), .rst(rst_b), .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
    .instr(instr_b), .instr_pc(instr_pc_b), .instr_valid(instr_valid_b), .instr_ready(1'b1),
    .redirect(1'b0), .redirect_pc(32'h0), .halted(halted_b)
  );

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [8];

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_a[mem_addr[7:0]];
    if (mem_rd_b) mem_rdata_b <= mem_b[mem_addr_b[2:0]];
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb_a [$];
  logic [63:0] sb_b [$];
  logic [31:0] max_addr_b = '0;
  logic        chk_halt_b = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard for DUT A: compare each accepted instruction.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      check("sb_a_nonempty", 64'(sb_a.size() != 0), 64'd1);
      if (sb_a.size() != 0) begin
        logic [63:0] e;
        e = sb_a.pop_front();
        check("instr_a", {instr, instr_pc}, e);
        $display("[TB] A accept instr=%h pc=%h", instr, instr_pc);
      end
    end
  end

  // Scoreboard and range watch for DUT B.
  always @(negedge clk) begin
    if (!rst_b) begin
      if (mem_rd_b && mem_addr_b > max_addr_b) max_addr_b = mem_addr_b;
      if (chk_halt_b) begin
        check("halt_b_after_pc4", 64'(halted_b), 64'd1);
        chk_halt_b = 1'b0;
      end
      if (instr_valid_b) begin
        check("sb_b_nonempty", 64'(sb_b.size() != 0), 64'd1);
        if (sb_b.size() != 0) begin
          logic [63:0] e;
          e = sb_b.pop_front();
          check("instr_b", {instr_b, instr_pc_b}, e);
          $display("[TB] B accept instr=%h pc=%h", instr_b, instr_pc_b);
        end
        if (instr_pc_b == 32'd4) chk_halt_b = 1'b1;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_image_a();
    sb_a.push_back({32'h2008_0005, 32'd0});
    sb_a.push_back({32'h0109_5020, 32'd4});
  endtask

  task automatic wait_halt(input string tag);
    for (int n = 0; n < 80 && !halted; n++) @(negedge clk);
    check(tag, 64'(halted), 64'd1);
    check({tag, "_sb_empty"}, 64'(sb_a.size()), 64'd0);
  endtask

  initial begin
    logic [7:0] img [8];
    int rd_cnt, first_rd, v1, v2;
    logic prev_v;

    img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem_a[i] = img[i];
    mem_a[12] = 8'hDE; mem_a[13] = 8'hAD; mem_a[14] = 8'hBE; mem_a[15] = 8'hEF;
    mem_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    sb_b.push_back({32'h1122_3344, 32'd0});
    sb_b.push_back({32'h5566_7788, 32'd4});

    // Reset state.
    @(negedge clk);
    check("rst_mem_rd", 64'(mem_rd), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);

    // Scenario 1: straight-line program, ready tied high.
    push_image_a();
    instr_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rst_b = 1'b0;
    rd_cnt = 0; first_rd = -1; v1 = -1; v2 = -1; prev_v = 1'b0;
    for (int n = 0; n < 100 && !halted; n++) begin
      @(negedge clk);
      if (mem_rd) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = n;
      end
      if (instr_valid && !prev_v) begin
        if (v1 < 0) v1 = n;
        else if (v2 < 0) v2 = n;
      end
      prev_v = instr_valid;
    end
    check("first_rd_cycle", 64'(first_rd), 64'd0);
    check("latency", 64'(v1 - first_rd), 64'd5);
    check("throughput", 64'(v2 - v1), 64'd6);
    check("rd_count", 64'(rd_cnt), 64'd12);
    check("s1_halted", 64'(halted), 64'd1);
    check("s1_sb_empty", 64'(sb_a.size()), 64'd0);

    // Scenario 2: consumer stalls for 10 cycles after the first valid.
    instr_ready = 1'b0;
    push_image_a();
    do_reset();
    for (int n = 0; n < 20 && !instr_valid; n++) @(negedge clk);
    check("s2_valid", 64'(instr_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("stall_instr", 64'(instr), 64'h2008_0005);
      check("stall_pc", 64'(instr_pc), 64'd0);
      check("stall_no_rd", 64'(mem_rd), 64'd0);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    wait_halt("s2_halted");

    // Scenario 3: redirect to 0xE during byte 2 of the pc-0 fetch.
    sb_a.push_back({32'hDEAD_BEEF, 32'd12});
    do_reset();
    for (int n = 0; n < 20 && !(mem_rd && mem_addr == 32'd2); n++) @(negedge clk);
    check("s3_at_byte2", 64'(mem_rd && mem_addr == 32'd2), 64'd1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_000E;
    @(negedge clk);
    redirect = 1'b0;
    check("redir_rd", 64'(mem_rd), 64'd1);
    check("redir_addr", 64'(mem_addr), 64'd12);
    wait_halt("s3_halted");

    // Scenario 4: reset asserted during DRAIN.
    push_image_a();
    do_reset();
    for (int n = 0; n < 20 && !(mem_rd && mem_addr == 32'd3); n++) @(negedge clk);
    check("s4_at_byte3", 64'(mem_rd && mem_addr == 32'd3), 64'd1);
    @(negedge clk);
    check("drain_no_rd", 64'(mem_rd), 64'd0);
    check("drain_no_valid", 64'(instr_valid), 64'd0);
    rst = 1'b1;
    #1;
    check("async_mem_rd", 64'(mem_rd), 64'd0);
    check("async_mem_addr", 64'(mem_addr), 64'd0);
    check("async_valid", 64'(instr_valid), 64'd0);
    check("async_instr", 64'(instr), 64'd0);
    check("async_halted", 64'(halted), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart_rd", 64'(mem_rd), 64'd1);
    check("restart_addr", 64'(mem_addr), 64'd0);
    wait_halt("s4_halted");

    // Scenario 5: redirects are ignored once halted.
    for (int i = 0; i < 3; i++) begin
      redirect = 1'b1;
      redirect_pc = 32'd0;
      @(negedge clk);
      redirect = 1'b0;
      check("halt_redir_rd", 64'(mem_rd), 64'd0);
      check("halt_redir_halted", 64'(halted), 64'd1);
      @(negedge clk);
      check("halt_redir_rd2", 64'(mem_rd), 64'd0);
    end

    // DUT B (MEM_BYTES = 8) has long since finished.
    check("b_halted", 64'(halted_b), 64'd1);
    check("b_sb_empty", 64'(sb_b.size()), 64'd0);
    check("b_addr_in_range", 64'(max_addr_b < 32'd8), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
